// File: rtl/ram_arbiter.sv
// Round-robin arbiter that sequences single-port RAM accesses from two requesters.
// Each transaction walks IDLE -> SETUP -> ACCESS (access_cycles) -> DONE.
module ram_arbiter #(
  parameter int addr_bits     = 16,
  parameter int data_bits     = 8,
  parameter int access_cycles = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [addr_bits-1:0] addr0,
  input  logic [data_bits-1:0] wdata0,
  output logic                 ack0,
  output logic [data_bits-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [addr_bits-1:0] addr1,
  input  logic [data_bits-1:0] wdata1,
  output logic                 ack1,
  output logic [data_bits-1:0] rdata1,
  output logic                 ram_we,
  output logic [addr_bits-1:0] ram_addr,
  output logic [data_bits-1:0] ram_wdata,
  input  logic [data_bits-1:0] ram_rdata,
  output logic                 busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] wait_load = 4'(access_cycles - 1);

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic       last_grant;
  logic       grant_port;
  logic       op_we;
  logic       grant_valid;
  logic       grant_sel;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    grant_valid = req0 | req1;
    grant_sel   = req1;
    if (req0 && req1) grant_sel = ~last_grant;
  end

  assign busy = (state != IDLE);

  // NOTE: every register here, ram_we included, is cleared by the async reset so
  // an abandoned write strobe drops immediately rather than at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_grant <= 1'b1;
      grant_port <= 1'b0;
      op_we      <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block
      // referring to the pre-edge values, independent of statement order.
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant_port <= grant_sel;
            last_grant <= grant_sel;
            op_we      <= grant_sel ? we1 : we0;
            ram_addr   <= grant_sel ? addr1 : addr0;
            ram_wdata  <= grant_sel ? wdata1 : wdata0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt <= wait_load;
          ram_we   <= op_we;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            ram_we <= 1'b0;
            state  <= DONE;
            if (grant_port) ack1 <= 1'b1;
            else            ack0 <= 1'b1;
            if (!op_we) begin
              if (grant_port) rdata1 <= ram_rdata;
              else            rdata0 <= ram_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: two instances (access_cycles 1 and 4), each
// with its own RAM model, a scoreboard of expected acks, and per-scenario tasks.
module tb_ram_arbiter;

  typedef struct {
    int         port;
    bit         we;
    logic [7:0] data;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0 [2], we0 [2], req1 [2], we1 [2];
  logic [15:0] addr0 [2], addr1 [2], ram_addr [2];
  logic [7:0]  wdata0 [2], wdata1 [2], rdata0 [2], rdata1 [2];
  logic [7:0]  ram_wdata [2], ram_rdata [2];
  logic        ack0 [2], ack1 [2], ram_we [2], busy [2];

  bit [7:0]    mem [2][65536];
  exp_t        sb0 [$];
  exp_t        sb1 [$];
  int          errors = 0;
  int          checks = 0;
  logic        prev_we [2];
  logic [15:0] prev_addr [2];
  logic [7:0]  prev_wdata [2];

  always #5 clk = ~clk;

  ram_arbiter #(.addr_bits(16), .data_bits(8), .access_cycles(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]), .ack0(ack0[0]), .rdata0(rdata0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]), .ack1(ack1[0]), .rdata1(rdata1[0]),
    .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
    .busy(busy[0])
  );

  ram_arbiter #(.addr_bits(16), .data_bits(8), .access_cycles(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]), .ack0(ack0[1]), .rdata0(rdata0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]), .ack1(ack1[1]), .rdata1(rdata1[1]),
    .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
    .busy(busy[1])
  );

  // RAM models: synchronous write, combinational read.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) if (ram_we[i]) mem[i][ram_addr[i]] <= ram_wdata[i];
  end
  assign ram_rdata[0] = mem[0][ram_addr[0]];
  assign ram_rdata[1] = mem[1][ram_addr[1]];

  task automatic observe(input int i);
    exp_t e;
    int   port;
    logic [7:0] rd;
    if (ack0[i] || ack1[i]) begin
      checks++;
      if (ack0[i] && ack1[i]) begin
        errors++; $display("FAIL ack_overlap inst%0d: ack0=%0b ack1=%0b, required one-hot", i, ack0[i], ack1[i]);
      end else if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
        errors++; $display("FAIL unexpected_ack inst%0d: ack seen with no pending transaction", i);
      end else begin
        e    = (i == 0) ? sb0.pop_front() : sb1.pop_front();
        port = ack1[i] ? 1 : 0;
        rd   = ack1[i] ? rdata1[i] : rdata0[i];
        checks++;
        if (port != e.port) begin
          errors++; $display("FAIL grant_order inst%0d: ack on port %0d, required port %0d", i, port, e.port);
        end
        if (!e.we) begin
          checks++;
          if (rd !== e.data) begin
            errors++; $display("FAIL read_data inst%0d port%0d: got %02h, required %02h", i, port, rd, e.data);
          end
        end
      end
    end
    if (ram_we[i] && prev_we[i]) begin
      checks++;
      if (ram_addr[i] !== prev_addr[i] || ram_wdata[i] !== prev_wdata[i]) begin
        errors++; $display("FAIL we_stable inst%0d: addr/data %04h/%02h, required %04h/%02h",
                           i, ram_addr[i], ram_wdata[i], prev_addr[i], prev_wdata[i]);
      end
    end
    prev_we[i] = ram_we[i]; prev_addr[i] = ram_addr[i]; prev_wdata[i] = ram_wdata[i];
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n) observe(i);
      else prev_we[i] = 1'b0;
    end
  end

  task automatic issue(input int i, input int port, input bit we, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rd, input bit track);
    exp_t e;
    if (port == 0) begin req0[i] = 1'b1; we0[i] = we; addr0[i] = a; wdata0[i] = d; end
    else           begin req1[i] = 1'b1; we1[i] = we; addr1[i] = a; wdata1[i] = d; end
    if (track) begin
      e.port = port; e.we = we; e.data = exp_rd;
      if (i == 0) sb0.push_back(e); else sb1.push_back(e);
    end
  endtask

  // Counts edges until the port's ack, checking the RAM bus on each strobe cycle.
  task automatic wait_ack(input int i, input int port, input int budget, input logic [15:0] exp_a,
                          input logic [7:0] exp_d, output int lat, output int we_cnt, output int busy_cnt);
    bit got = 1'b0;
    lat = 0; we_cnt = 0; busy_cnt = 0;
    while (!got && lat < budget) begin
      @(posedge clk); #1; lat++;
      if (busy[i]) busy_cnt++;
      if (ram_we[i]) begin
        we_cnt++; checks++;
        if (ram_addr[i] !== exp_a || ram_wdata[i] !== exp_d) begin
          errors++; $display("FAIL strobe_bus inst%0d: addr/data %04h/%02h, required %04h/%02h",
                             i, ram_addr[i], ram_wdata[i], exp_a, exp_d);
        end
      end
      if (((port == 0) ? ack0[i] : ack1[i]) === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL ack_timeout inst%0d port%0d: no ack within %0d cycles", i, port, budget); end
    if (port == 0) req0[i] = 1'b0; else req1[i] = 1'b0;
  endtask

  task automatic run_tx(input int i, input int port, input bit we, input logic [15:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, input int ac);
    int lat, wc, bc;
    @(posedge clk); #1;
    issue(i, port, we, a, d, exp_rd, 1'b1);
    wait_ack(i, port, 40, a, d, lat, wc, bc);
    checks++; if (lat != 2 + ac) begin errors++; $display("FAIL latency inst%0d: got %0d, required %0d", i, lat, 2 + ac); end
    checks++; if (wc != (we ? ac : 0)) begin errors++; $display("FAIL we_cycles inst%0d: got %0d, required %0d", i, wc, we ? ac : 0); end
    checks++; if (bc != 2 + ac) begin errors++; $display("FAIL busy_cycles inst%0d: got %0d, required %0d", i, bc, 2 + ac); end
    @(posedge clk); #1;
    checks++;
    if (ack0[i] !== 1'b0 || ack1[i] !== 1'b0 || busy[i] !== 1'b0) begin
      errors++; $display("FAIL after_done inst%0d: ack0=%0b ack1=%0b busy=%0b, required 0/0/0", i, ack0[i], ack1[i], busy[i]);
    end
  endtask

  task automatic check_reset_state(input int i, input string tag);
    checks++;
    if (busy[i] !== 1'b0 || ram_we[i] !== 1'b0 || ram_addr[i] !== 16'h0 || ram_wdata[i] !== 8'h0 ||
        ack0[i] !== 1'b0 || ack1[i] !== 1'b0 || rdata0[i] !== 8'h0 || rdata1[i] !== 8'h0) begin
      errors++;
      $display("FAIL %s inst%0d: busy=%0b we=%0b addr=%04h wdata=%02h ack=%0b%0b rdata=%02h/%02h, required all zero",
               tag, i, busy[i], ram_we[i], ram_addr[i], ram_wdata[i], ack0[i], ack1[i], rdata0[i], rdata1[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0, "reset");
    check_reset_state(1, "reset");
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write();
    run_tx(0, 0, 1'b1, 16'h1234, 8'hA5, 8'h00, 1);
    checks++;
    if (mem[0][16'h1234] !== 8'hA5) begin errors++; $display("FAIL write_landed: mem[1234]=%02h, required a5", mem[0][16'h1234]); end
  endtask

  task automatic test_read();
    run_tx(0, 0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1);
    checks++;
    if (rdata1[0] !== 8'h00) begin errors++; $display("FAIL rdata1_idle: got %02h, required 00", rdata1[0]); end
  endtask

  task automatic test_addr_change();
    int lat, wc, bc;
    @(posedge clk); #1;
    issue(0, 0, 1'b1, 16'h0010, 8'h77, 8'h00, 1'b1);
    @(posedge clk); #1;
    addr0[0] = 16'h0001; wdata0[0] = 8'hEE;
    wait_ack(0, 0, 40, 16'h0010, 8'h77, lat, wc, bc);
    checks++; if (lat + 1 != 3) begin errors++; $display("FAIL latency_chg: got %0d, required 3", lat + 1); end
    checks++; if (wc != 1) begin errors++; $display("FAIL we_cycles_chg: got %0d, required 1", wc); end
    @(posedge clk); #1;
    checks++;
    if (mem[0][16'h0010] !== 8'h77 || mem[0][16'h0001] !== 8'h00) begin
      errors++; $display("FAIL inflight_latch: mem[0010]=%02h mem[0001]=%02h, required 77/00", mem[0][16'h0010], mem[0][16'h0001]);
    end
    checks++;
    if (rdata0[0] !== 8'hA5) begin errors++; $display("FAIL rdata_hold: got %02h, required a5", rdata0[0]); end
    run_tx(0, 0, 1'b0, 16'h0001, 8'h00, 8'h00, 1);
    run_tx(0, 0, 1'b0, 16'h0010, 8'h00, 8'h77, 1);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int acks = 0, cyc = 0, last = 0;
    do_reset();
    #1;
    check_reset_state(0, "rr_reset");
    for (int k = 0; k < 4; k++) begin
      e.port = k % 2; e.we = 1'b0; e.data = (k % 2 == 0) ? 8'hA5 : 8'h77;
      sb0.push_back(e);
    end
    @(posedge clk); #1;
    issue(0, 0, 1'b0, 16'h1234, 8'h00, 8'h00, 1'b0);
    issue(0, 1, 1'b0, 16'h0010, 8'h00, 8'h00, 1'b0);
    while (acks < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (ack0[0] || ack1[0]) begin
        acks++;
        if (acks > 1) begin
          checks++;
          if (cyc - last != 4) begin errors++; $display("FAIL rr_throughput: ack spacing %0d, required 4", cyc - last); end
        end
        last = cyc;
      end
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    checks++;
    if (acks != 4) begin errors++; $display("FAIL rr_count: got %0d acks, required 4", acks); end
    @(posedge clk); #1;
  endtask

  task automatic test_long_write();
    run_tx(1, 1, 1'b1, 16'h0000, 8'h3C, 8'h00, 4);
    checks++;
    if (mem[1][16'h0000] !== 8'h3C) begin errors++; $display("FAIL long_write_landed: got %02h, required 3c", mem[1][16'h0000]); end
    run_tx(1, 1, 1'b0, 16'h0000, 8'h00, 8'h3C, 4);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    issue(0, 0, 1'b1, 16'h0300, 8'h99, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (ram_we[0] !== 1'b1) begin errors++; $display("FAIL mid_access: ram_we=%0b, required 1", ram_we[0]); end
    #2; rst_n = 1'b0; req0[0] = 1'b0;
    #1;
    checks++;
    if (ram_we[0] !== 1'b0 || busy[0] !== 1'b0 || ack0[0] !== 1'b0 || ram_addr[0] !== 16'h0) begin
      errors++; $display("FAIL async_reset: we=%0b busy=%0b ack0=%0b addr=%04h, required 0/0/0/0000",
                         ram_we[0], busy[0], ack0[0], ram_addr[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state(0, "post_abort");
    run_tx(0, 0, 1'b1, 16'h0300, 8'h5A, 8'h00, 1);
    run_tx(0, 0, 1'b0, 16'h0300, 8'h00, 8'h5A, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = '0; wdata0[i] = '0;
      req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = '0; wdata1[i] = '0;
      prev_we[i] = 1'b0; prev_addr[i] = '0; prev_wdata[i] = '0;
    end
    test_reset();
    test_write();
    test_read();
    test_addr_change();
    test_round_robin();
    test_long_write();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", sb0.size(), sb1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
